wb_arbiter: RTL and testbench
=============================

# wb_arbiter

- Writeback arbiter that drives the register file's single write port (`WriteReg`, `WriteData`, `RegWrite`).
- Merges two result sources:
  - Source A: the in-order pipeline writeback. It has priority and no backpressure.
  - Source B: the long-latency units (loads, multiply). It enters through a valid/ready handshake and waits in a small FIFO.
- Also provides a per-register busy mask for the hazard unit and a starvation hold for the pipeline.
- Sits between the WB stage and the register file.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries for source B. Power of two, 2..16.
- `STARVE_LIMIT`, 3: consecutive unserved cycles with the FIFO non-empty before `hold` asserts. Range 1..15.

Ports:
- `clock` input 1: single clock, rising edge.
- `reset_n` input 1: reset, asynchronous and active-low.
- `a_valid` input 1: pipeline result present this cycle.
- `a_reg` input 5: destination register for A.
- `a_data` input 64: result for A.
- `b_valid` input 1: long-latency result offered.
- `b_ready` output 1: block accepts B this cycle; equals `!full`.
- `b_reg` input 5: destination register for B.
- `b_data` input 64: result for B.
- `hold` output 1: pipeline must freeze WB; `a_valid` is ignored while high.
- `busy_mask` output 32: bit r set while any valid FIFO entry targets register r.
- `fifo_count` output clog2(DEPTH)+1: occupied FIFO entries.
- `WriteReg` output 5: register-file write address, registered.
- `WriteData` output 64: register-file write data, registered.
- `RegWrite` output 1: register-file write enable, registered.

## Operation
- Grant, evaluated once per cycle in this order:
  1. If `hold`=1: pop the FIFO head to the write port.
  2. Else if `a_valid` and `a_reg`≠31: write A.
  3. Else if the FIFO is non-empty: pop the head.
  4. Else: `RegWrite`=0 next cycle.
- Register 31 (XZR) is never written:
  - A targeting 31 is dropped and frees the port for a FIFO pop.
  - B targeting 31 completes the handshake and is discarded without being enqueued.
- FIFO behaviour:
  - Circular buffer with wrap-around pointers.
  - Push when `b_valid && b_ready && b_reg!=31`.
  - Push and pop in the same cycle leaves the count unchanged. When empty, a push and a pop cannot both occur except through the fast path (see Configuration).
  - `b_ready`=0 only when `fifo_count`==DEPTH. No push is possible when full, even if a pop occurs that cycle.
- Starvation counter, 4 bits:
  - Increments at each edge where the FIFO is non-empty and no pop occurs.
  - Clears on any pop or when the FIFO is empty.
  - `hold` = (counter ≥ STARVE_LIMIT), decoded from the registered counter. It therefore lasts exactly one cycle per starvation event.
- `busy_mask` is the OR of one-hot(dest) over valid FIFO entries, updated combinationally from FIFO state.
- Ordering rule: A may overtake a queued B. Upstream must stall any instruction whose destination or source has `busy_mask` set. The block does not reorder to fix this.
- Reset (`reset_n` low, at any time, including mid-transfer):
  - FIFO is emptied and pointers are zeroed.
  - Counter=0, `hold`=0, `RegWrite`=0, `WriteReg`=0, `WriteData`=0, `busy_mask`=0, `fifo_count`=0.
  - `b_ready`=1. Handshakes during reset are ignored and in-flight entries are lost.

## Timing
- Write outputs are updated at the rising edge. The register file captures them at the following edge.
- A presented in cycle c (granted) → `RegWrite`=1 with A's reg/data in cycle c+1.
- B accepted in cycle c, FIFO path → earliest write in cycle c+2.
- With the fast path compiled in and eligible → write in cycle c+1.
- `b_ready`, `busy_mask`, `fifo_count` and `hold` are functions of registered state only; there is no combinational path from inputs.
- Throughput: one register-file write per cycle maximum.

## Configuration
- Macro: `WB_FASTPATH_EN`.
- Defined:
  - When the FIFO is empty, `hold`=0, and A is not granted (absent or reg 31), an accepted B (reg≠31) is written directly in cycle c+1.
  - It is not enqueued, and `busy_mask` never shows it.
- Undefined: every B passes through the FIFO, with a minimum latency of 2 cycles.

## Test plan
- A only: `a_valid`=1, `a_reg`=5, `a_data`=0x1234 in cycle 0 → cycle 1 shows `RegWrite`=1, `WriteReg`=5, `WriteData`=0x1234. An A with `a_reg`=31 → `RegWrite`=0.
- B only, no fast path: B reg=7, data=0xAA accepted in cycle 0 → `busy_mask`[7]=1 in cycle 1 → write reg 7 in cycle 2 → `busy_mask`=0 in cycle 3. With `WB_FASTPATH_EN` defined: write in cycle 1 and `busy_mask` stays 0.
- Full FIFO: push 4 B while A is valid every cycle → `fifo_count`=4 and `b_ready`=0. Keep A continuously valid → `hold`=1 exactly in the 4th cycle after the first push. The head is popped that cycle and A's input that cycle is ignored.
- Wrap-around: 10 B pushes interleaved with idle A → writes emerge in push order with data intact across the pointer wrap.
- B reg=31 → handshake completes, `fifo_count` unchanged, no write.
- Reset mid-operation: `fifo_count`=3, assert `reset_n`=0 asynchronously → all outputs go to their reset values immediately, and no stale write appears after release.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges in-order pipeline results (A) with queued long-latency results (B)
// onto the single register-file write port. Optional B bypass when idle: WB_FASTPATH_EN.
module wb_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   a_valid,
  input  logic [4:0]             a_reg,
  input  logic [63:0]            a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [4:0]             b_reg,
  input  logic [63:0]            b_data,
  output logic                   hold,
  output logic [31:0]            busy_mask,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [4:0]             WriteReg,
  output logic [63:0]            WriteData,
  output logic                   RegWrite
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] vld;
  logic [4:0]       mreg  [DEPTH];
  logic [63:0]      mdata [DEPTH];
  logic [3:0]       starve;

  logic empty, full, a_grant, pop, b_take, fast, push;

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign b_ready    = !full;
  assign hold       = (starve >= 4'(STARVE_LIMIT));
  assign fifo_count = count;

  // hold masks A out of a_grant, so the head wins whenever hold is high
  assign a_grant = !hold && a_valid && (a_reg != 5'd31);
  assign pop     = !empty && !a_grant;
  assign b_take  = b_valid && b_ready && (b_reg != 5'd31);

`ifdef WB_FASTPATH_EN
  assign fast = b_take && empty && !hold && !a_grant;
`else
  assign fast = 1'b0;
`endif

  assign push = b_take && !fast;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      vld    <= '0;
      starve <= '0;
    end else begin
      if (push) begin
        wptr      <= wptr + PW'(1);
        vld[wptr] <= 1'b1;
      end
      if (pop) begin
        rptr      <= rptr + PW'(1);
        vld[rptr] <= 1'b0;
      end
      count <= count + CW'(push) - CW'(pop);
      if (empty || pop)
        starve <= '0;
      else if (starve != 4'hF)
        starve <= starve + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mreg[wptr]  <= b_reg;
      mdata[wptr] <= b_data;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (vld[PW'(i)]) busy_mask[mreg[PW'(i)]] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else if (pop) begin
      RegWrite  <= 1'b1;
      WriteReg  <= mreg[rptr];
      WriteData <= mdata[rptr];
    end else if (a_grant) begin
      RegWrite  <= 1'b1;
      WriteReg  <= a_reg;
      WriteData <= a_data;
    end else if (fast) begin
      RegWrite  <= 1'b1;
      WriteReg  <= b_reg;
      WriteData <= b_data;
    end else begin
      RegWrite  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed, table-driven bench for wb_arbiter (DEPTH=4, STARVE_LIMIT=3); table rows follow
// WB_FASTPATH_EN where B latency differs.
module tb_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        a_valid, b_valid, b_ready, hold, RegWrite;
  logic [4:0]  a_reg, b_reg, WriteReg;
  logic [63:0] a_data, b_data, WriteData;
  logic [31:0] busy_mask;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad   = 0;

  wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .hold(hold), .busy_mask(busy_mask), .fifo_count(fifo_count),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        av;  logic [4:0] ar; logic [63:0] ad;
    logic        bv;  logic [4:0] br; logic [63:0] bd;
    logic        rw;  logic [4:0] wr; logic [63:0] wd;
    logic        rdy; logic [2:0] cnt; logic hold; logic [31:0] mask;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic av, input logic [4:0] ar, input logic [63:0] ad,
                     input logic bv, input logic [4:0] br, input logic [63:0] bd,
                     input logic rw, input logic [4:0] wr, input logic [63:0] wd,
                     input logic rdy, input logic [2:0] cnt, input logic hd,
                     input logic [31:0] mask);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.bv = bv; v.br = br; v.bd = bd;
    v.rw = rw; v.wr = wr; v.wd = wd; v.rdy = rdy; v.cnt = cnt; v.hold = hd; v.mask = mask;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [63:0] ad,
                       input logic bv, input logic [4:0] br, input logic [63:0] bd);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " RegWrite"},   64'(RegWrite),   64'd0);
    chk({tag, " WriteReg"},   64'(WriteReg),   64'd0);
    chk({tag, " WriteData"},  WriteData,       64'd0);
    chk({tag, " hold"},       64'(hold),       64'd0);
    chk({tag, " busy_mask"},  64'(busy_mask),  64'd0);
    chk({tag, " fifo_count"}, 64'(fifo_count), 64'd0);
    chk({tag, " b_ready"},    64'(b_ready),    64'd1);
  endtask

  initial begin
    // A only
    add(1, 5,  64'h1234, 0, 0, 0,  1, 5, 64'h1234, 1, 0, 0, 0);
    add(1, 31, 64'h55,   0, 0, 0,  0, 0, 0,        1, 0, 0, 0);
    add(1, 0,  '1,       0, 0, 0,  1, 0, '1,       1, 0, 0, 0);
    add(0, 0,  0,        0, 0, 0,  0, 0, 0,        1, 0, 0, 0);
    // B only, reg 7
`ifdef WB_FASTPATH_EN
    add(0, 0, 0, 1, 7, 64'hAA,  1, 7, 64'hAA, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,       0, 0, 0,      1, 0, 0, 0);
`else
    add(0, 0, 0, 1, 7, 64'hAA,  0, 0, 0,      1, 1, 0, 32'h80);
    add(0, 0, 0, 0, 0, 0,       1, 7, 64'hAA, 1, 0, 0, 0);
`endif
    add(0, 0, 0, 0, 0, 0,       0, 0, 0,      1, 0, 0, 0);
    // B to XZR: accepted, discarded
    add(0, 0, 0, 1, 31, 64'h99, 0, 0, 0,      1, 0, 0, 0);
    // fill FIFO under continuous A, starvation hold in 4th cycle after first push
    add(1, 1, 64'hA1, 1, 10, 64'hB0,  1, 1,  64'hA1, 1, 1, 0, 32'h0000_0400);
    add(1, 2, 64'hA2, 1, 11, 64'hB1,  1, 2,  64'hA2, 1, 2, 0, 32'h0000_0C00);
    add(1, 3, 64'hA3, 1, 12, 64'hB2,  1, 3,  64'hA3, 1, 3, 0, 32'h0000_1C00);
    add(1, 4, 64'hA4, 1, 13, 64'hB3,  1, 4,  64'hA4, 0, 4, 1, 32'h0000_3C00);
    add(1, 5, 64'hA5, 1, 14, 64'hB4,  1, 10, 64'hB0, 1, 3, 0, 32'h0000_3800);
    add(0, 0, 0,      0, 0,  0,       1, 11, 64'hB1, 1, 2, 0, 32'h0000_3000);
    add(0, 0, 0,      0, 0,  0,       1, 12, 64'hB2, 1, 1, 0, 32'h0000_2000);
    add(0, 0, 0,      0, 0,  0,       1, 13, 64'hB3, 1, 0, 0, 0);
    add(0, 0, 0,      0, 0,  0,       0, 0,  0,      1, 0, 0, 0);
    // wrap-around: 10 back-to-back B pushes with A idle
    for (int k = 0; k < 10; k++) begin
`ifdef WB_FASTPATH_EN
      add(0, 0, 0, 1, 5'(16 + k), 64'hC000 + 64'(k),
          1, 5'(16 + k), 64'hC000 + 64'(k), 1, 0, 0, 0);
`else
      if (k == 0)
        add(0, 0, 0, 1, 16, 64'hC000, 0, 0, 0, 1, 1, 0, 32'h0001_0000);
      else
        add(0, 0, 0, 1, 5'(16 + k), 64'hC000 + 64'(k),
            1, 5'(15 + k), 64'hC000 + 64'(k - 1), 1, 1, 0, 32'h1 << (16 + k));
`endif
    end
`ifdef WB_FASTPATH_EN
    add(0, 0, 0, 0, 0, 0, 0, 0,  0,        1, 0, 0, 0);
`else
    add(0, 0, 0, 0, 0, 0, 1, 25, 64'hC009, 1, 0, 0, 0);
`endif
    add(0, 0, 0, 0, 0, 0, 0, 0,  0,        1, 0, 0, 0);

    drive(0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    #3;
    chk_reset("initial_reset");
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].bv, tbl[i].br, tbl[i].bd);
      @(negedge clock);
      chk($sformatf("row%0d RegWrite", i),   64'(RegWrite),   64'(tbl[i].rw));
      chk($sformatf("row%0d b_ready", i),    64'(b_ready),    64'(tbl[i].rdy));
      chk($sformatf("row%0d fifo_count", i), 64'(fifo_count), 64'(tbl[i].cnt));
      chk($sformatf("row%0d hold", i),       64'(hold),       64'(tbl[i].hold));
      chk($sformatf("row%0d busy_mask", i),  64'(busy_mask),  64'(tbl[i].mask));
      if (tbl[i].rw) begin
        chk($sformatf("row%0d WriteReg", i),  64'(WriteReg), 64'(tbl[i].wr));
        chk($sformatf("row%0d WriteData", i), WriteData,     tbl[i].wd);
      end
    end

    // asynchronous reset with three entries queued
    for (int k = 0; k < 3; k++) begin
      drive(1, 5'(2 + k), 64'hD0 + 64'(k), 1, 5'(20 + k), 64'hE0 + 64'(k));
      @(negedge clock);
    end
    chk("pre_reset fifo_count", 64'(fifo_count), 64'd3);
    chk("pre_reset busy_mask",  64'(busy_mask),  64'h0070_0000);
    chk("pre_reset RegWrite",   64'(RegWrite),   64'd1);
    drive(1, 9, 64'hF1, 1, 9, 64'hF2);
    #2 reset_n = 1'b0;
    #1;
    chk_reset("async_reset");
    @(negedge clock);
    @(negedge clock);
    chk_reset("during_reset");
    drive(0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk($sformatf("post_reset%0d RegWrite", k),   64'(RegWrite),   64'd0);
      chk($sformatf("post_reset%0d fifo_count", k), 64'(fifo_count), 64'd0);
      chk($sformatf("post_reset%0d busy_mask", k),  64'(busy_mask),  64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
